mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's fetch/load/store bus. It accepts one request at a time from the main controller's memory port and holds it for a programmable number of wait states. It then performs a word-wide read or byte-enabled write on an internal RAM and returns a response through a valid/ready handshake. It is the target end of the interface that the controller drives during FETCH and WRITEBACK.

---
 rtl/mem_bus_pkg.sv | 39 +++
 rtl/word_ram.sv | 37 +++
 rtl/mem_responder.sv | 128 ++++++++++++
 tb/tb_mem_responder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-side bus responder.
// The request/response records are sized for the widest address the bus
// can carry; narrower instances zero-extend into them.
package mem_bus_pkg;

    // Width of the wait-state down-counter (wait states 0..15).
    localparam int WAIT_W     = 4;

    // Widest byte address the request record can hold.
    localparam int BUS_ADDR_W = 32;

    typedef struct packed {
        logic                  we;
        logic [BUS_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
        logic [3:0]            be;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_rsp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rsp_state_t;

    // A request is rejected when it is not word aligned or when its word
    // index falls beyond the last RAM word.
    function automatic logic addr_err(input logic [BUS_ADDR_W-1:0] addr,
                                      input int unsigned           depth);
        logic [BUS_ADDR_W-1:0] word_idx;
        word_idx = {2'b00, addr[BUS_ADDR_W-1:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= depth);
    endfunction

endpackage

// File: rtl/word_ram.sv
// Single-port word RAM with per-byte write enables and a registered read.
// The read register only loads on an enabled read, so it keeps presenting
// the last word read while the port sits idle.
module word_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Byte-masked write or registered word read, only when enabled.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request at a time, waits a fixed
// number of wait states, performs a single RAM access and then holds the
// response until the requester takes it. Every output comes from a
// register or from the state register, never straight from an input.
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_state_t        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    mem_req_t          req_q, req_d;
    logic              rd_ok_q, rd_ok_d;
    logic              rsp_err_q, rsp_err_d;

    logic              req_err;
    logic              access;
    logic              ram_en;
    logic [31:0]       ram_rdata;
    mem_rsp_t          rsp;

    // The error flag is decoded from the latched address, so it is fixed
    // for the whole life of the request.
    assign req_err = addr_err(req_q.addr, DEPTH);

    // The access happens in the last WAIT cycle. A reset in that same cycle
    // suppresses it so an interrupted write never reaches the RAM.
    assign access = (state_q == WAIT) && (cnt_q == '0);
    assign ram_en = access && !req_err && !reset;

    word_ram #(
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (req_q.we),
        .be_i    (req_q.be),
        .addr_i  (req_q.addr[RAM_AW+1:2]),
        .wdata_i (req_q.wdata),
        .rdata_o (ram_rdata)
    );

    // Next-state logic: latch on accept, count down wait states, access,
    // then wait for the response handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        rd_ok_d   = rd_ok_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.we    = req_we;
                    req_d.addr  = BUS_ADDR_W'(req_addr);
                    req_d.wdata = req_wdata;
                    req_d.be    = req_be;
                    cnt_d       = WAIT_W'(WAIT_CYCLES);
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end else begin
                    rd_ok_d   = !req_q.we && !req_err;
                    rsp_err_d = req_err;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, request latch and response flags with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            rd_ok_q   <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            rd_ok_q   <= rd_ok_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Read data is the RAM's own output register; it is masked to zero for
    // writes, errors and after reset.
    assign rsp.rdata = rd_ok_q ? ram_rdata : 32'h0;
    assign rsp.err   = rsp_err_q;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp.rdata;
    assign rsp_err   = rsp.err;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a table of transactions on a two-wait-state
// instance, hand-written backpressure and reset sequences, and a
// back-to-back run on a zero-wait-state instance.
module tb_mem_responder;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 256;
    localparam int WC     = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0 = 1'b0, req_we0 = 1'b0, rsp_ready0 = 1'b1;
    logic [11:0] req_addr0 = '0;
    logic [31:0] req_wdata0 = '0;
    logic [3:0]  req_be0 = '0;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;

    mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sbQ[$];
    vec_t vecs[19];
    vec_t b2b[4];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out", name);
    endtask

    // Drives one request on the WAIT_CYCLES=2 instance; pushes the expected
    // response when the request is seen accepted. Entered after a rising edge.
    task automatic applyStimulus(input vec_t v);
        logic ok;
        ok = 1'b0;
        req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_be = v.be;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            failNow("accept");
            req_valid = 1'b0;
        end else begin
            sbQ.push_back('{v.expRdata, v.expErr, cycle});
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
    endtask

    // Waits for the response, compares it with the scoreboard and its latency.
    task automatic awaitResponse(input string tag, input int expLat);
        logic ok;
        exp_t e;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            failNow({tag, " response"});
        end else if (sbQ.size() == 0) begin
            failNow({tag, " scoreboard empty"});
        end else begin
            e = sbQ.pop_front();
            checkOutput({tag, " rdata"}, rsp_rdata, e.rdata);
            checkOutput({tag, " err"}, 32'(rsp_err), 32'(e.err));
            checkOutput({tag, " latency"}, 32'(cycle - e.cyc), 32'(expLat));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic found;
        int   nAcc, nRsp, lastAcc, lateValid;
        logic accepted;
        exp_t e;
        vec_t v;

        vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 12'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 12'h020, 32'h11223344, 4'hF, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 12'h020, 32'h000000AA, 4'h1, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 12'h020, 32'h0,        4'h0, 32'h112233AA, 1'b0};
        vecs[5]  = '{1'b0, 12'h013, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[6]  = '{1'b1, 12'h000, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
        vecs[7]  = '{1'b1, 12'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 12'h000, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
        vecs[9]  = '{1'b1, 12'h030, 32'h0BADF00D, 4'hF, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 12'h030, 32'h12345678, 4'h0, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 12'h030, 32'h0,        4'h0, 32'h0BADF00D, 1'b0};
        vecs[12] = '{1'b1, 12'h3FC, 32'h00000000, 4'hF, 32'h0,        1'b0};
        vecs[13] = '{1'b1, 12'h3FC, 32'h87654321, 4'hA, 32'h0,        1'b0};
        vecs[14] = '{1'b0, 12'h3FC, 32'h0,        4'h0, 32'h87004300, 1'b0};
        vecs[15] = '{1'b0, 12'h3FE, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[16] = '{1'b1, 12'h040, 32'h55667788, 4'hF, 32'h0,        1'b0};
        vecs[17] = '{1'b1, 12'h011, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[18] = '{1'b0, 12'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};

        b2b[0] = '{1'b1, 12'h008, 32'h01020304, 4'hF, 32'h0,        1'b0};
        b2b[1] = '{1'b1, 12'h00C, 32'h0A0B0C0D, 4'hF, 32'h0,        1'b0};
        b2b[2] = '{1'b0, 12'h008, 32'h0,        4'h0, 32'h01020304, 1'b0};
        b2b[3] = '{1'b0, 12'h00C, 32'h0,        4'h0, 32'h0A0B0C0D, 1'b0};

        $display("[TB] reset");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset0 req_ready", 32'(req_ready0), 32'd1);
        checkOutput("reset0 rsp_valid", 32'(rsp_valid0), 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] vector table");
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i]);
            awaitResponse($sformatf("vec%0d", i), WC + 2);
        end

        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        v = '{1'b0, 12'h010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
        applyStimulus(v);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("bp rsp_valid seen", 32'(found), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput($sformatf("bp%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
            checkOutput($sformatf("bp%0d rdata", k), rsp_rdata, 32'hDEADBEEF);
            checkOutput($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp release rsp_valid", 32'(rsp_valid), 32'd1);
        if (sbQ.size() == 0) begin
            failNow("bp scoreboard empty");
        end else begin
            e = sbQ.pop_front();
            checkOutput("bp release rdata", rsp_rdata, e.rdata);
            checkOutput("bp release err", 32'(rsp_err), 32'(e.err));
        end
        @(negedge clk);
        checkOutput("bp idle rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("bp idle req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] reset during write wait");
        req_we = 1'b1; req_addr = 12'h040; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        req_valid = 1'b1;
        @(negedge clk);
        checkOutput("midrst ready before accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst req_ready", 32'(req_ready), 32'd1);
        checkOutput("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("midrst rsp_err", 32'(rsp_err), 32'd0);
        lateValid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) lateValid++;
        end
        checkOutput("midrst no late response", 32'(lateValid), 32'd0);
        @(posedge clk);
        #1;
        v = '{1'b0, 12'h040, 32'h0, 4'h0, 32'h55667788, 1'b0};
        applyStimulus(v);
        awaitResponse("midrst readback", WC + 2);

        $display("[TB] zero wait states, back-to-back");
        nAcc = 0;
        nRsp = 0;
        lastAcc = 0;
        req_we0 = b2b[0].we; req_addr0 = b2b[0].addr;
        req_wdata0 = b2b[0].wdata; req_be0 = b2b[0].be;
        req_valid0 = 1'b1;
        for (int c = 0; c < 40 && nRsp < 4; c++) begin
            @(negedge clk);
            accepted = 1'b0;
            if (rsp_valid0) begin
                if (sbQ.size() == 0) begin
                    failNow("b2b scoreboard empty");
                end else begin
                    e = sbQ.pop_front();
                    checkOutput($sformatf("b2b%0d rdata", nRsp), rsp_rdata0, e.rdata);
                    checkOutput($sformatf("b2b%0d err", nRsp), 32'(rsp_err0), 32'(e.err));
                    checkOutput($sformatf("b2b%0d latency", nRsp), 32'(cycle - e.cyc), 32'd2);
                end
                nRsp++;
            end
            if (req_valid0 && req_ready0) begin
                if (nAcc > 0) begin
                    checkOutput($sformatf("b2b%0d spacing", nAcc), 32'(cycle - lastAcc), 32'd3);
                end
                lastAcc = cycle;
                sbQ.push_back('{b2b[nAcc].expRdata, b2b[nAcc].expErr, cycle});
                nAcc++;
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            if (accepted) begin
                if (nAcc < 4) begin
                    req_we0 = b2b[nAcc].we; req_addr0 = b2b[nAcc].addr;
                    req_wdata0 = b2b[nAcc].wdata; req_be0 = b2b[nAcc].be;
                end else begin
                    req_valid0 = 1'b0;
                end
            end
        end
        if (nRsp < 4) failNow("b2b responses");
        checkOutput("b2b accepts", 32'(nAcc), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
